sys_cmd_rx_ctrl: RTL and testbench

Parametrised receive-side system controller. Decodes the command byte stream delivered by the UART receiver and drives register-file write/read, ALU operand loading and execution, and the ALU clock-gate enable. Supersedes the fixed-width controller: register-file depth, data width, operand addresses and gate hold time are parameters. It adds burst write, an inter-byte timeout, and error reporting. Sits between the UART Rx/data-sync stage and the register file / ALU / clock-gate cell.

---
 rtl/sys_cmd_pkg.sv | 16 +
 rtl/cmd_timeout_cnt.sv | 17 +
 rtl/sys_cmd_rx_ctrl.sv | 149 ++++++++++++++
 tb/tb_sys_cmd_rx_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: opcodes, FSM state encoding and helpers for the command receive controller
package sys_cmd_pkg;
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] CMD_BURST   = 8'hEE;
  typedef enum logic [3:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR, S_R_WAIT, S_OP_A, S_OP_B,
    S_FUN, S_ALU_WAIT, S_GATE_HOLD, S_BW_ADDR, S_BW_CNT, S_BW_DATA
  } state_t;
  // States waiting on the next byte of a frame are subject to the inter-byte timeout
  function automatic logic timed(state_t s);
    return !(s inside {S_IDLE, S_R_WAIT, S_ALU_WAIT, S_GATE_HOLD});
  endfunction
endpackage

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: inter-byte down-counter; expire pulses when TIMEOUT_CYC idle cycles elapse
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic CLK,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) cnt <= CW'(TIMEOUT_CYC);
    else cnt <= (!en || clr) ? CW'(TIMEOUT_CYC) : cnt - 1'b1;
  assign expire = (TIMEOUT_CYC != 0) && en && !clr && cnt == CW'(1);
endmodule

// File: rtl/sys_cmd_rx_ctrl.sv
// sys_cmd_rx_ctrl: decodes the UART command stream into register-file, ALU and clock-gate controls
module sys_cmd_rx_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 1023,
  parameter int GATE_HOLD   = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Rx_P_Data,
  input  logic              RxValid,
  input  logic              Busy,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic [ADDR_W-1:0] Reg_File_Adress,
  output logic              WrEN,
  output logic              RdEN,
  output logic [DATA_W-1:0] WrData,
  output logic              CLK_GATE_EN,
  output logic              Cmd_Err,
  output logic              Addr_Err,
  output logic              Timeout_Err,
  output logic              Overrun_Err,
  output logic              Ctrl_Idle
);
  localparam int HW = GATE_HOLD > 1 ? $clog2(GATE_HOLD) : 1;
  state_t state, state_n, cmd_state;
  logic [ADDR_W-1:0] addr_r, addr_n, rf_addr_n;
  logic [DATA_W-1:0] bcnt_r, bcnt_n, wr_data_n;
  logic [HW-1:0] hold_r, hold_n;
  logic [FUN_W-1:0] fun_n;
  logic alu_en_n, wr_en_n, rd_en_n, cmd_err_n, addr_err_n, ov_err_n, expire, addr_ok;
  cmd_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .CLK(CLK), .Reset(Reset), .en(timed(state)), .clr(RxValid), .expire(expire)
  );
  assign addr_ok = (Rx_P_Data >> ADDR_W) == '0;
  assign cmd_state = Rx_P_Data == DATA_W'(CMD_WR)      ? S_W_ADDR :
                     Rx_P_Data == DATA_W'(CMD_RD)      ? S_R_ADDR :
                     Rx_P_Data == DATA_W'(CMD_ALU_OP)  ? S_OP_A   :
                     Rx_P_Data == DATA_W'(CMD_ALU_NOP) ? S_FUN    :
                     Rx_P_Data == DATA_W'(CMD_BURST)   ? S_BW_ADDR : S_IDLE;
  always_comb begin
    state_n = state;
    addr_n = addr_r;
    bcnt_n = bcnt_r;
    hold_n = hold_r;
    fun_n = ALU_FUN;
    rf_addr_n = Reg_File_Adress;
    wr_data_n = WrData;
    alu_en_n = 1'b0;
    wr_en_n = 1'b0;
    rd_en_n = 1'b0;
    cmd_err_n = 1'b0;
    addr_err_n = 1'b0;
    ov_err_n = 1'b0;
    if (expire) state_n = S_IDLE;
    else case (state)
      S_IDLE: if (RxValid) begin
        state_n = cmd_state;
        cmd_err_n = cmd_state == S_IDLE;
      end
      S_W_ADDR, S_R_ADDR, S_BW_ADDR: if (RxValid) begin
        addr_err_n = !addr_ok;
        addr_n = Rx_P_Data[ADDR_W-1:0];
        state_n = !addr_ok ? S_IDLE : state == S_W_ADDR ? S_W_DATA : state == S_R_ADDR ? S_R_WAIT : S_BW_CNT;
      end
      S_W_DATA, S_BW_DATA: if (RxValid) begin
        wr_en_n = 1'b1;
        rf_addr_n = addr_r;
        wr_data_n = Rx_P_Data;
        addr_n = addr_r + 1'b1;
        bcnt_n = bcnt_r - 1'b1;
        state_n = (state == S_W_DATA || bcnt_r == DATA_W'(1)) ? S_IDLE : S_BW_DATA;
      end
      S_OP_A, S_OP_B: if (RxValid) begin
        wr_en_n = 1'b1;
        rf_addr_n = state == S_OP_A ? ADDR_W'(OPA_ADDR) : ADDR_W'(OPB_ADDR);
        wr_data_n = Rx_P_Data;
        state_n = state == S_OP_A ? S_OP_B : S_FUN;
      end
      S_FUN: if (RxValid) begin
        fun_n = Rx_P_Data[FUN_W-1:0];
        state_n = S_ALU_WAIT;
      end
      // A byte arriving while waiting is dropped and the wait does not progress that cycle
      S_R_WAIT, S_ALU_WAIT: begin
        ov_err_n = RxValid;
        if (!RxValid && !Busy) begin
          rd_en_n = state == S_R_WAIT;
          alu_en_n = state == S_ALU_WAIT;
          rf_addr_n = state == S_R_WAIT ? addr_r : Reg_File_Adress;
          hold_n = HW'(GATE_HOLD - 1);
          state_n = (state == S_ALU_WAIT && GATE_HOLD > 0) ? S_GATE_HOLD : S_IDLE;
        end
      end
      S_GATE_HOLD: begin
        ov_err_n = RxValid;
        hold_n = hold_r - 1'b1;
        state_n = hold_r == '0 ? S_IDLE : S_GATE_HOLD;
      end
      S_BW_CNT: if (RxValid) begin
        bcnt_n = Rx_P_Data;
        state_n = Rx_P_Data == '0 ? S_IDLE : S_BW_DATA;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state <= S_IDLE;
      addr_r <= '0;
      bcnt_r <= '0;
      hold_r <= '0;
      ALU_EN <= 1'b0;
      ALU_FUN <= '0;
      Reg_File_Adress <= '0;
      WrEN <= 1'b0;
      RdEN <= 1'b0;
      WrData <= '0;
      CLK_GATE_EN <= 1'b0;
      Cmd_Err <= 1'b0;
      Addr_Err <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun_Err <= 1'b0;
      Ctrl_Idle <= 1'b1;
    end else begin
      state <= state_n;
      addr_r <= addr_n;
      bcnt_r <= bcnt_n;
      hold_r <= hold_n;
      ALU_EN <= alu_en_n;
      ALU_FUN <= fun_n;
      Reg_File_Adress <= rf_addr_n;
      WrEN <= wr_en_n;
      RdEN <= rd_en_n;
      WrData <= wr_data_n;
      CLK_GATE_EN <= state inside {S_FUN, S_ALU_WAIT, S_GATE_HOLD};
      Cmd_Err <= cmd_err_n;
      Addr_Err <= addr_err_n;
      Timeout_Err <= expire;
      Overrun_Err <= ov_err_n;
      Ctrl_Idle <= state_n == S_IDLE;
    end
endmodule

// File: tb/tb_sys_cmd_rx_ctrl.sv
// tb_sys_cmd_rx_ctrl: directed timing checks plus random frames scored against a frame-level model
module tb_sys_cmd_rx_ctrl;
  localparam int DW = 8, AW = 4, FW = 4, TO = 40, GH = 2;
  logic CLK = 1'b0, Reset = 1'b1, RxValid = 1'b0, Busy = 1'b0;
  logic [DW-1:0] Rx_P_Data = '0;
  logic ALU_EN, WrEN, RdEN, CLK_GATE_EN, Cmd_Err, Addr_Err, Timeout_Err, Overrun_Err, Ctrl_Idle;
  logic [FW-1:0] ALU_FUN;
  logic [AW-1:0] Reg_File_Adress;
  logic [DW-1:0] WrData;
  int tests = 0, fails = 0;
  logic [AW+DW-1:0] wr_seen[$];
  logic [AW-1:0] rd_seen[$];
  logic [FW-1:0] alu_seen[$];
  int cmd_n = 0, addr_n = 0, to_n = 0, ov_n = 0;

  always #5 CLK = ~CLK;

  sys_cmd_rx_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW), .OPA_ADDR(0), .OPB_ADDR(1),
                    .TIMEOUT_CYC(TO), .GATE_HOLD(GH)) dut (
    .CLK(CLK), .Reset(Reset), .Rx_P_Data(Rx_P_Data), .RxValid(RxValid), .Busy(Busy),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .Reg_File_Adress(Reg_File_Adress), .WrEN(WrEN),
    .RdEN(RdEN), .WrData(WrData), .CLK_GATE_EN(CLK_GATE_EN), .Cmd_Err(Cmd_Err),
    .Addr_Err(Addr_Err), .Timeout_Err(Timeout_Err), .Overrun_Err(Overrun_Err), .Ctrl_Idle(Ctrl_Idle)
  );

  always @(negedge CLK) if (!Reset) begin
    if (WrEN) wr_seen.push_back({Reg_File_Adress, WrData});
    if (RdEN) rd_seen.push_back(Reg_File_Adress);
    if (ALU_EN) alu_seen.push_back(ALU_FUN);
    cmd_n += int'(Cmd_Err);
    addr_n += int'(Addr_Err);
    to_n += int'(Timeout_Err);
    ov_n += int'(Overrun_Err);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge
  task automatic send(logic [7:0] b, int gap = 0);
    Rx_P_Data = b;
    RxValid = 1'b1;
    @(negedge CLK);
    RxValid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd_any;
    logic [7:0] a, b, d, f, v;
    int kind, n, w, ecmd, eaddr;
    logic [7:0] fb[$];
    logic [AW+DW-1:0] ew[$];
    logic [AW-1:0] er[$];
    logic [FW-1:0] ea[$];
    tick(2);
    chk("rst_idle", 32'(Ctrl_Idle), 1);
    chk("rst_wren", 32'({WrEN, RdEN, ALU_EN, CLK_GATE_EN}), 0);
    chk("rst_err", 32'({Cmd_Err, Addr_Err, Timeout_Err, Overrun_Err}), 0);
    chk("rst_addr_data", 32'({Reg_File_Adress, WrData, ALU_FUN}), 0);
    Reset = 1'b0;
    tick();
    // single write
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_en", 32'(WrEN), 1);
    chk("wr_addr", 32'(Reg_File_Adress), 5);
    chk("wr_data", 32'(WrData), 'h3C);
    tick();
    chk("wr_pulse_width", 32'(WrEN), 0);
    chk("wr_idle", 32'(Ctrl_Idle), 1);
    // read held off by Busy, with an overrun byte while waiting
    Busy = 1'b1;
    send(8'hBB); send(8'h07); send(8'h11);
    chk("overrun", 32'(Overrun_Err), 1);
    rd_any = RdEN;
    for (int i = 0; i < 10; i++) begin
      rd_any |= RdEN;
      tick();
    end
    chk("rd_while_busy", 32'(rd_any), 0);
    Busy = 1'b0;
    tick();
    chk("rd_en", 32'(RdEN), 1);
    chk("rd_addr", 32'(Reg_File_Adress), 7);
    tick();
    chk("rd_pulse_width", 32'(RdEN), 0);
    chk("rd_idle", 32'(Ctrl_Idle), 1);
    // ALU with operands and clock-gate window
    send(8'hCC); send(8'h12);
    chk("opa_wr", 32'({WrEN, Reg_File_Adress, WrData}), 32'({1'b1, 4'd0, 8'h12}));
    send(8'h34);
    chk("opb_wr", 32'({WrEN, Reg_File_Adress, WrData}), 32'({1'b1, 4'd1, 8'h34}));
    send(8'h01);
    chk("gate_before_alu", 32'({CLK_GATE_EN, ALU_EN}), 'b10);
    tick();
    chk("alu_en", 32'({ALU_EN, CLK_GATE_EN}), 'b11);
    chk("alu_fun", 32'(ALU_FUN), 1);
    for (int i = 0; i < GH; i++) begin
      tick();
      chk("gate_hold", 32'({CLK_GATE_EN, ALU_EN}), 'b10);
    end
    tick();
    chk("gate_fall", 32'({CLK_GATE_EN, Ctrl_Idle}), 'b01);
    // burst with address wrap
    send(8'hEE); send(8'h0E); send(8'h03);
    for (int i = 0; i < 3; i++) begin
      send(8'hA1 + 8'(i));
      chk("burst_wr", 32'({WrEN, Reg_File_Adress, WrData}), 32'({1'b1, 4'((14 + i) % 16), 8'hA1 + 8'(i)}));
    end
    chk("burst_idle", 32'(Ctrl_Idle), 1);
    // error cases
    send(8'hAA); send(8'h20);
    chk("addr_err", 32'({Addr_Err, WrEN, Ctrl_Idle}), 'b101);
    tick();
    send(8'h55);
    chk("cmd_err", 32'({Cmd_Err, Ctrl_Idle}), 'b11);
    tick();
    send(8'hAA);
    tick(TO - 1);
    chk("timeout_early", 32'({Timeout_Err, Ctrl_Idle}), 'b00);
    tick();
    chk("timeout", 32'({Timeout_Err, Ctrl_Idle, WrEN}), 'b110);
    tick();
    send(8'hAA);
    tick(TO - 1);
    send(8'h03);
    chk("timeout_edge_accept", 32'({Timeout_Err, Ctrl_Idle}), 'b00);
    send(8'h5A);
    chk("timeout_edge_wr", 32'({WrEN, Reg_File_Adress, WrData}), 32'({1'b1, 4'd3, 8'h5A}));
    tick();
    // reset mid-burst
    send(8'hEE); send(8'h02); send(8'h03); send(8'hB1);
    chk("pre_reset_wr", 32'({WrEN, Reg_File_Adress}), 32'({1'b1, 4'd2}));
    Reset = 1'b1;
    #1;
    chk("reset_clear", 32'({WrEN, Reg_File_Adress, WrData, Ctrl_Idle}), 1);
    tick();
    Reset = 1'b0;
    tick();
    send(8'hAA); send(8'h01); send(8'hFF);
    chk("post_reset_wr", 32'({WrEN, Reg_File_Adress, WrData}), 32'({1'b1, 4'd1, 8'hFF}));
    tick(2);
    // random frames against the frame-level model
    wr_seen.delete(); rd_seen.delete(); alu_seen.delete();
    cmd_n = 0; addr_n = 0; to_n = 0; ov_n = 0;
    for (int fr = 0; fr < 80; fr++) begin
      fb.delete(); ew.delete(); er.delete(); ea.delete();
      ecmd = 0; eaddr = 0;
      kind = int'($urandom_range(0, 5));
      a = ($urandom_range(0, 9) == 0) ? 8'(16 + $urandom_range(0, 239)) : 8'($urandom_range(0, 15));
      b = 8'($urandom); d = 8'($urandom); f = 8'($urandom);
      Busy = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          fb.push_back(8'hAA); fb.push_back(a);
          if (a < 16) begin fb.push_back(d); ew.push_back({a[3:0], d}); end else eaddr++;
        end
        1: begin
          fb.push_back(8'hBB); fb.push_back(a);
          if (a < 16) er.push_back(a[3:0]); else eaddr++;
        end
        2: begin
          fb.push_back(8'hCC); fb.push_back(b); fb.push_back(d); fb.push_back(f);
          ew.push_back({4'd0, b}); ew.push_back({4'd1, d}); ea.push_back(4'(f % 16));
        end
        3: begin
          fb.push_back(8'hDD); fb.push_back(f);
          ea.push_back(4'(f % 16));
        end
        4: begin
          fb.push_back(8'hEE); fb.push_back(a);
          if (a < 16) begin
            n = int'($urandom_range(0, 4));
            fb.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
              v = 8'($urandom);
              fb.push_back(v);
              ew.push_back({4'((a + i) % 16), v});
            end
          end else eaddr++;
        end
        default: begin
          do v = 8'($urandom); while (v inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});
          fb.push_back(v);
          ecmd++;
        end
      endcase
      foreach (fb[i]) send(fb[i], int'($urandom_range(0, 3)));
      tick(int'($urandom_range(0, 4)));
      Busy = 1'b0;
      w = 0;
      while (!(Ctrl_Idle && !CLK_GATE_EN) && w < 100) begin
        tick();
        w++;
      end
      chk("frame_done", 32'(w < 100), 1);
      tick();
      chk("rnd_wr_count", wr_seen.size(), ew.size());
      foreach (ew[i]) if (i < wr_seen.size()) chk("rnd_wr", 32'(wr_seen[i]), 32'(ew[i]));
      chk("rnd_rd_count", rd_seen.size(), er.size());
      foreach (er[i]) if (i < rd_seen.size()) chk("rnd_rd", 32'(rd_seen[i]), 32'(er[i]));
      chk("rnd_alu_count", alu_seen.size(), ea.size());
      foreach (ea[i]) if (i < alu_seen.size()) chk("rnd_alu", 32'(alu_seen[i]), 32'(ea[i]));
      chk("rnd_errs", 32'({8'(cmd_n), 8'(addr_n), 8'(to_n), 8'(ov_n)}), 32'({8'(ecmd), 8'(eaddr), 16'd0}));
      wr_seen.delete(); rd_seen.delete(); alu_seen.delete();
      cmd_n = 0; addr_n = 0; to_n = 0; ov_n = 0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
